regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-lane register file for the superscalar core; successor to the fixed two-lane `regs` block.
- Sits between `dec` and the ALU lanes:
  - takes per-lane source/destination addresses and writeback ports;
  - returns registered operands plus per-lane issue enables from intra-group hazard checks.
- Adds a configurable lane count, per-port write enables, write-to-read bypass, deterministic write-collision priority, a hold input and reset.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- LANES, 2, number of issue lanes (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
- LINK_REG, 31, register written implicitly by jal; a lower-lane destination equal to it blocks later lanes

Ports:
- clk  in  1  clock, rising edge
- rs  in  1  reset, synchronous, active-low
- hold  in  1  1 = freeze all outputs, no new read/issue (writes still performed)
- src_a  in  LANES*ADDR_W  per-lane source A address; lane k at [k*ADDR_W +: ADDR_W]
- src_b  in  LANES*ADDR_W  per-lane source B address
- dst  in  LANES*ADDR_W  per-lane destination address, used for hazard check only
- dst_vld  in  LANES  1 = lane k instruction writes dst
- we  in  LANES  per-lane writeback enable
- waddr  in  LANES*ADDR_W  per-lane writeback address
- wdata  in  LANES*DATA_W  per-lane writeback data
- rdata_a  out  LANES*DATA_W  registered operand A per lane
- rdata_b  out  LANES*DATA_W  registered operand B per lane
- lane_en  out  LANES  registered issue enable per lane

Behaviour:
- **Reset.** Sampled on rising clk with rs=0.
  - All 2**ADDR_W entries cleared to 0.
  - rdata_a, rdata_b = 0; lane_en = 0.
  - Reset overrides hold and we.
  - Reset asserted mid-operation discards that cycle's writes.
- **Writes.** Every rising edge with rs=1, independent of hold.
  - Each lane with we[k]=1 writes wdata[k] to waddr[k].
  - With ZERO_REG=1, writes to address 0 are dropped.
- **Write collision.** Several lanes with the same waddr and we=1: the highest-index lane wins, since it is later in program order.
- **Reads.** One-cycle latency; when hold=0, the rising edge registers regs[src] into rdata.
  - Bypass: if a read address matches any waddr with we=1 in the same cycle, rdata takes that wdata. The same priority rule applies (highest lane wins).
  - Address 0 always returns 0 when ZERO_REG=1, including when bypassed.
- **Hold.** When hold=1, rdata_a, rdata_b and lane_en keep their previous values.
- **Issue enable.** Registered with the operands.
  - lane_en[0] = 1 (rs=1, hold=0).
  - Lane k>0 is enabled iff lane k-1 is enabled and, for every lower lane j<k with dst_vld[j]=1 and dst[j]≠0, none of the following hold:
    - RAW: src_a[k]==dst[j] or src_b[k]==dst[j];
    - WAW: dst_vld[k] and dst[k]==dst[j];
    - link: dst[j]==LINK_REG.
  - Once a lane is disabled, all higher lanes are disabled (in-order issue).
  - A destination of register 0 never creates a hazard when ZERO_REG=1.
- **Arithmetic.** None; there are no width conversions and addresses are used as given.
- **Boundaries.**
  - LANES=1: lane_en is constant 1 after reset.
  - Simultaneous write and read of the same address in the same edge returns the new data (bypass).
  - Hold together with writes: the array updates, outputs do not.
  - Bypass is evaluated on the next edge after hold deasserts, so there are no stale reads after a held write.

Decomposition:
- Shared package `core_pkg`: DATA_W/ADDR_W defaults, LINK_REG constant, and lane slice helper functions (lane_addr(k), lane_data(k)).
- One natural sub-module, `lane_hazard`:
  - combinational;
  - inputs: flattened src_a, src_b, dst and dst_vld;
  - output: unregistered LANES enable vector;
  - instantiated once.
- The storage array, write priority, bypass and output registers stay in `regfile_mp`.

Test Plan:
1. Reset (LANES=2): rs=0 for 1 cycle with we=11, waddr=5/6 -> after release, reads of 5 and 6 return 0; lane_en=00 during reset, 11 next cycle for independent addresses.
2. Collision: we=11, waddr both 9, wdata lane0=0x11 and lane1=0x22 -> subsequent read of 9 returns 0x22.
3. Bypass: write 0xDEAD to r7 while lane0 src_a=7 in the same edge -> rdata_a lane0 = 0xDEAD one cycle later; write to r0 gives read 0.
4. Hazards (LANES=3):
   - dst0=8, src_a1=8 -> lane_en=001;
   - dst0=8, src_b2=8, lane1 independent -> lane_en=011;
   - dst0=31 -> lane_en=001;
   - dst0=0 with src_a1=0 -> lane_en=111.
5. Hold: hold=1 for 3 cycles while writing 0x5 to r3 with lane0 src_a=3 -> rdata unchanged; first cycle after hold=0 returns 0x5.
6. Reset mid-stream: rs=0 asserted together with hold=1 and we=1 -> all outputs 0, the write is discarded, the array is cleared.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, the link register and helpers
// that locate a lane's field inside a flattened per-lane bus.
package core_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int LINK_REG_DEF = 31;

    function automatic int lane_addr(input int k, input int w = ADDR_W_DEF);
        return k * w;
    endfunction

    function automatic int lane_data(input int k, input int w = DATA_W_DEF);
        return k * w;
    endfunction

endpackage

// File: rtl/lane_hazard.sv
// Intra-group hazard check: decides which lanes of an issue group may go
// this cycle, in order, given the lanes' sources and destinations.
module lane_hazard
    import core_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LANES    = 2,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic [LANES*ADDR_W-1:0] src_a,
    input  logic [LANES*ADDR_W-1:0] src_b,
    input  logic [LANES*ADDR_W-1:0] dst,
    input  logic [LANES-1:0]        dst_vld,
    output logic [LANES-1:0]        lane_en
);

    always_comb begin
        logic              ok;
        logic [ADDR_W-1:0] dj;
        lane_en    = '0;
        lane_en[0] = 1'b1;
        for (int k = 1; k < LANES; k++) begin
            ok = lane_en[k-1];
            for (int j = 0; j < k; j++) begin
                dj = dst[lane_addr(j, ADDR_W) +: ADDR_W];
                // Register 0 never carries a dependency, so it is skipped.
                if (dst_vld[j] && dj != '0) begin
                    if (src_a[lane_addr(k, ADDR_W) +: ADDR_W] == dj ||
                        src_b[lane_addr(k, ADDR_W) +: ADDR_W] == dj ||
                        (dst_vld[k] && dst[lane_addr(k, ADDR_W) +: ADDR_W] == dj) ||
                        dj == ADDR_W'(LINK_REG))
                        ok = 1'b0;
                end
            end
            lane_en[k] = ok;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-lane register file: per-lane writeback with highest-lane priority,
// registered operand reads with same-edge bypass, and registered issue enables.
module regfile_mp
    import core_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LANES    = 2,
    parameter int ZERO_REG = 1,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                    clk,
    input  logic                    rs,
    input  logic                    hold,
    input  logic [LANES*ADDR_W-1:0] src_a,
    input  logic [LANES*ADDR_W-1:0] src_b,
    input  logic [LANES*ADDR_W-1:0] dst,
    input  logic [LANES-1:0]        dst_vld,
    input  logic [LANES-1:0]        we,
    input  logic [LANES*ADDR_W-1:0] waddr,
    input  logic [LANES*DATA_W-1:0] wdata,
    output logic [LANES*DATA_W-1:0] rdata_a,
    output logic [LANES*DATA_W-1:0] rdata_b,
    output logic [LANES-1:0]        lane_en
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [LANES-1:0]        hz_en;
    logic [LANES*DATA_W-1:0] rd_a_nxt;
    logic [LANES*DATA_W-1:0] rd_b_nxt;

    lane_hazard #(
        .ADDR_W  (ADDR_W),
        .LANES   (LANES),
        .LINK_REG(LINK_REG)
    ) u_hazard (
        .src_a  (src_a),
        .src_b  (src_b),
        .dst    (dst),
        .dst_vld(dst_vld),
        .lane_en(hz_en)
    );

    // Later lanes are later in program order, so iterating upward lets the
    // highest writing lane win a collision.
    always_ff @(posedge clk) begin
        if (!rs) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (we[k] && !(ZERO_REG != 0 && waddr[lane_addr(k, ADDR_W) +: ADDR_W] == '0))
                    mem[waddr[lane_addr(k, ADDR_W) +: ADDR_W]] <= wdata[lane_data(k, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [DATA_W-1:0] va;
        logic [DATA_W-1:0] vb;
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            ra = src_a[lane_addr(k, ADDR_W) +: ADDR_W];
            rb = src_b[lane_addr(k, ADDR_W) +: ADDR_W];
            va = mem[ra];
            vb = mem[rb];
            for (int j = 0; j < LANES; j++) begin
                if (we[j] && waddr[lane_addr(j, ADDR_W) +: ADDR_W] == ra)
                    va = wdata[lane_data(j, DATA_W) +: DATA_W];
                if (we[j] && waddr[lane_addr(j, ADDR_W) +: ADDR_W] == rb)
                    vb = wdata[lane_data(j, DATA_W) +: DATA_W];
            end
            // The zero register wins even over a same-edge bypass.
            if (ZERO_REG != 0 && ra == '0)
                va = '0;
            if (ZERO_REG != 0 && rb == '0)
                vb = '0;
            rd_a_nxt[lane_data(k, DATA_W) +: DATA_W] = va;
            rd_b_nxt[lane_data(k, DATA_W) +: DATA_W] = vb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            rdata_a <= '0;
            rdata_b <= '0;
            lane_en <= '0;
        end else if (!hold) begin
            rdata_a <= rd_a_nxt;
            rdata_b <= rd_b_nxt;
            lane_en <= hz_en;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (3 lanes): a reference array predicts each
// cycle's outputs into a scoreboard that is drained after the clock edge.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NL = 3;

    logic            clk = 1'b0;
    logic            rs;
    logic            hold;
    logic [NL*AW-1:0] src_a, src_b, dst, waddr;
    logic [NL-1:0]   dst_vld, we, lane_en;
    logic [NL*DW-1:0] wdata, rdata_a, rdata_b;

    typedef struct {
        string            tag;
        logic [NL*DW-1:0] a;
        logic [NL*DW-1:0] b;
        logic [NL-1:0]    en;
    } exp_t;

    exp_t             sb[$];
    logic [DW-1:0]    ref_mem [32];
    logic [NL*DW-1:0] last_a, last_b;
    logic [NL-1:0]    last_en;
    int               checks = 0;
    int               errors = 0;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .LANES(NL), .ZERO_REG(1), .LINK_REG(31)
    ) dut (
        .clk(clk), .rs(rs), .hold(hold),
        .src_a(src_a), .src_b(src_b), .dst(dst), .dst_vld(dst_vld),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .lane_en(lane_en)
    );

    always #5 clk = ~clk;

    task automatic idleInputs();
        src_a = '0; src_b = '0; dst = '0; dst_vld = '0;
        we = '0; waddr = '0; wdata = '0;
    endtask

    task automatic setRead(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b);
        src_a[k*AW +: AW] = a;
        src_b[k*AW +: AW] = b;
    endtask

    task automatic setDst(input int k, input logic [AW-1:0] d);
        dst[k*AW +: AW] = d;
        dst_vld[k] = 1'b1;
    endtask

    task automatic setWrite(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[k] = 1'b1;
        waddr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = ref_mem[a];
        for (int k = 0; k < NL; k++)
            if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*DW +: DW];
        if (a == 0) v = '0;
        return v;
    endfunction

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed size 0 required >0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (rdata_a === e.a) else begin
                errors++;
                $error("[TB] FAIL %s rdata_a: observed %h expected %h", e.tag, rdata_a, e.a);
            end
            checks++;
            assert (rdata_b === e.b) else begin
                errors++;
                $error("[TB] FAIL %s rdata_b: observed %h expected %h", e.tag, rdata_b, e.b);
            end
            checks++;
            assert (lane_en === e.en) else begin
                errors++;
                $error("[TB] FAIL %s lane_en: observed %b expected %b", e.tag, lane_en, e.en);
            end
        end
    endtask

    // Drives one cycle: predicts the post-edge outputs, advances the reference
    // array, then compares after the edge. exp_en is the directed issue mask.
    task automatic applyStimulus(input string tag, input logic rs_v, input logic hold_v,
                                 input logic [NL-1:0] exp_en);
        exp_t e;
        rs = rs_v;
        hold = hold_v;
        e.tag = tag;
        if (!rs_v) begin
            e.a = '0; e.b = '0; e.en = '0;
        end else if (hold_v) begin
            e.a = last_a; e.b = last_b; e.en = last_en;
        end else begin
            for (int k = 0; k < NL; k++) begin
                e.a[k*DW +: DW] = refRead(src_a[k*AW +: AW]);
                e.b[k*DW +: DW] = refRead(src_b[k*AW +: AW]);
            end
            e.en = exp_en;
        end
        sb.push_back(e);
        last_a = e.a; last_b = e.b; last_en = e.en;
        if (!rs_v) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        end else begin
            for (int k = 0; k < NL; k++)
                if (we[k] && waddr[k*AW +: AW] != 0)
                    ref_mem[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
        end
        @(posedge clk);
        #1;
        checkOutput();
        idleInputs();
    endtask

    initial begin
        rs = 1'b0;
        hold = 1'b0;
        idleInputs();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;

        // Reset discards the same-edge writes to r5/r6.
        setWrite(0, 5, 32'hAAAA_0005);
        setWrite(1, 6, 32'hBBBB_0006);
        applyStimulus("reset", 1'b0, 1'b0, 3'b000);
        setRead(0, 5, 6);
        setRead(1, 6, 5);
        applyStimulus("post_reset_read", 1'b1, 1'b0, 3'b111);

        setWrite(0, 9, 32'h11);
        setWrite(1, 9, 32'h22);
        applyStimulus("collision_write", 1'b1, 1'b0, 3'b111);
        setRead(0, 9, 9);
        setRead(2, 9, 0);
        applyStimulus("collision_read", 1'b1, 1'b0, 3'b111);

        setWrite(0, 7, 32'hDEAD);
        setRead(0, 7, 7);
        applyStimulus("bypass_r7", 1'b1, 1'b0, 3'b111);
        setWrite(1, 7, 32'hBEEF);
        setWrite(2, 7, 32'hCAFE);
        setRead(1, 7, 9);
        applyStimulus("bypass_priority", 1'b1, 1'b0, 3'b111);
        setWrite(0, 0, 32'h1234);
        setRead(0, 0, 0);
        applyStimulus("bypass_r0", 1'b1, 1'b0, 3'b111);
        setRead(0, 0, 7);
        applyStimulus("read_r0", 1'b1, 1'b0, 3'b111);

        setDst(0, 8);
        setRead(1, 8, 1);
        applyStimulus("raw_a_lane1", 1'b1, 1'b0, 3'b001);
        setDst(0, 8);
        setDst(1, 3);
        setRead(1, 1, 2);
        setRead(2, 4, 8);
        applyStimulus("raw_b_lane2", 1'b1, 1'b0, 3'b011);
        setDst(0, 31);
        setRead(1, 1, 2);
        applyStimulus("link_reg", 1'b1, 1'b0, 3'b001);
        setDst(0, 0);
        setDst(1, 0);
        setRead(1, 0, 0);
        setRead(2, 0, 0);
        applyStimulus("dst_zero", 1'b1, 1'b0, 3'b111);
        setDst(0, 10);
        setDst(1, 10);
        applyStimulus("waw", 1'b1, 1'b0, 3'b001);
        setDst(1, 12);
        setRead(2, 12, 1);
        applyStimulus("raw_lane1_to_2", 1'b1, 1'b0, 3'b011);

        setRead(0, 3, 7);
        applyStimulus("hold_prime", 1'b1, 1'b0, 3'b111);
        for (int c = 0; c < 3; c++) begin
            setWrite(0, 3, 32'h5);
            setRead(0, 3, 3);
            setDst(0, 8);
            setRead(1, 8, 8);
            applyStimulus("hold", 1'b1, 1'b1, 3'b000);
        end
        setRead(0, 3, 3);
        applyStimulus("hold_release", 1'b1, 1'b0, 3'b111);

        setWrite(2, 12, 32'h77);
        applyStimulus("pre_reset_write", 1'b1, 1'b0, 3'b111);
        setRead(0, 12, 12);
        applyStimulus("pre_reset_read", 1'b1, 1'b0, 3'b111);
        setWrite(0, 13, 32'h99);
        setRead(0, 12, 13);
        applyStimulus("mid_reset", 1'b0, 1'b1, 3'b000);
        setRead(0, 12, 13);
        setRead(1, 9, 7);
        setRead(2, 3, 5);
        applyStimulus("after_mid_reset", 1'b1, 1'b0, 3'b111);

        // Random traffic with no destinations, so every lane issues.
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(1, 0) == 1)
                    setWrite(k, AW'($urandom_range(7, 0)), $urandom);
                setRead(k, AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0)));
            end
            applyStimulus("random", 1'b1, 1'b0, 3'b111);
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
